// File: rtl/cpu_pkg.sv
// Shared CPU-pipeline types and constants for the stage select/handshake blocks.
// Slicing helper keeps flattened-bus indexing consistent across modules.
package cpu_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [1:0]        sel;
    logic              err;
  } stage_hs_t;

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice with a global stall; in_ready depends on
// registered state and stage_wait only, never on out_ready.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stage_wait,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             r_live;
  logic             r_main_vld;
  logic [WIDTH-1:0] r_main_dat;
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_skid_dat;
  logic             w_in_fire;
  logic             w_out_fire;

  // r_live keeps in_ready low until the first edge after reset release
  assign in_ready   = r_live & ~r_skid_vld & ~stage_wait;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_main_vld & out_ready & ~stage_wait;
  assign out_valid  = r_main_vld;
  assign out_data   = r_main_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live     <= 1'b0;
      r_main_vld <= 1'b0;
      r_main_dat <= '0;
      r_skid_vld <= 1'b0;
      r_skid_dat <= '0;
    end else begin
      r_live <= 1'b1;
      if (!r_main_vld) begin
        if (w_in_fire) begin
          r_main_vld <= 1'b1;
          r_main_dat <= in_data;
        end
      end else if (w_out_fire) begin
        if (r_skid_vld) begin
          r_main_dat <= r_skid_dat;
          r_skid_vld <= 1'b0;
        end else if (w_in_fire) begin
          r_main_dat <= in_data;
        end else begin
          r_main_vld <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_skid_vld <= 1'b1;
        r_skid_dat <= in_data;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// N:1 word select feeding a stallable skid buffer; one cycle from accept to
// out_valid, throughput one word per cycle, out-of-range selects yield zero + err.
module mux_nto1_pipe
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stage_wait,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        select_bits,
  input  logic [NUM_IN*WIDTH-1:0] d_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    sel_err
);

  localparam int PW = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] w_word;
  logic             w_err;
  logic [PW-1:0]    w_in_pld;
  logic [PW-1:0]    w_out_pld;

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (select_bits == SEL_W'(i)) w_word = d_in[slice_lsb(i, WIDTH) +: WIDTH];
    end
  end

  assign w_err    = (int'(select_bits) >= NUM_IN);
  assign w_in_pld = {w_err, select_bits, w_word};

  skid_buffer #(.WIDTH(PW)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .stage_wait (stage_wait),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (w_in_pld),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (w_out_pld)
  );

  assign {sel_err, sel_out, data_out} = w_out_pld;

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised, clocked successor to the 8-bit 2:1 datapath mux.
- Selects one of NUM_IN input words of WIDTH bits, registers the result, and hands it downstream over a valid/ready handshake.
- Includes a 2-entry skid buffer, so upstream never sees a combinational path from out_ready.
- Global stage_wait stall input freezes all transfers. The block sits between CPU pipeline stages: operand select, writeback select, ALU-B select.

Parameters:
- WIDTH, 8: data word width in bits.
- NUM_IN, 4: number of selectable inputs, >= 2.
- SEL_W, $clog2(NUM_IN): select width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- stage_wait  input  1  global stall; while high, no handshake completes on either side.
- in_valid  input  1  upstream word and select are valid.
- in_ready  output  1  block can accept a word this cycle.
- select_bits  input  SEL_W  index of the chosen input.
- d_in  input  NUM_IN*WIDTH  flattened inputs; word i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  data_out holds a valid word.
- out_ready  input  1  downstream accepts.
- data_out  output  WIDTH  selected, registered word.
- sel_out  output  SEL_W  select index that produced data_out.
- sel_err  output  1  data_out came from an out-of-range select.

Behaviour:
- Reset (async, immediate): out_valid=0, data_out=0, sel_out=0, sel_err=0, skid empty. in_ready=0 while rst is high, and 1 from the first clock after release if stage_wait=0.
- Accept: in_fire = in_valid & in_ready. in_ready = !skid_full & !stage_wait. This is registered-state only, with no path from out_ready.
- Emit: out_fire = out_valid & out_ready & !stage_wait.
- Mux: word = d_in[select_bits*WIDTH +: WIDTH], sampled at in_fire.
- Out-of-range select (select_bits >= NUM_IN, possible when NUM_IN is not a power of 2): stored word = 0, err flag = 1. It is still a normal transfer.
- Latency: 1 cycle from in_fire to out_valid when the output register is empty or draining.
- Storage: output register (main) plus one skid entry. Each holds {word, sel, err}.
- Main empty: in_fire loads main.
- Main full and out_fire: main loads from skid if skid is full, else from the input if in_fire. Otherwise main goes empty.
- Main full, no out_fire, in_fire: the word goes into skid, which sets skid_full and drops in_ready next cycle.
- Simultaneous in_fire and out_fire with skid empty: main is replaced, with no bubble (throughput 1/cycle).
- Skid full and out_fire: skid moves to main and skid empties. in_fire is impossible that cycle because in_ready=0.
- stage_wait high: all registers hold, including out_valid, data_out and skid. The mux output is not re-sampled. Inputs may change freely.
- Order is strictly FIFO. No word is dropped or duplicated.
- Reset mid-transfer: all pending words are discarded and outputs return to reset values immediately.
- data_out is stable while out_valid=1 and not out_fire.

Decomposition:
- Shared package cpu_pkg: DATA_W=8 default, a stage handshake struct {valid, data, sel, err} typedef, and a localparam helper for flattened-bus slicing.
- One natural sub-module: skid_buffer (generic WIDTH-payload 2-entry valid/ready register slice, stall input). mux_nto1_pipe = combinational select + skid_buffer with payload {err, sel, word}.

Test Plan:
1. Reset
   - Stimulus: assert rst mid-stream with main and skid both full.
   - Required: out_valid=0, data_out=0 and sel_err=0 immediately. After release, in_ready=1 next edge.
2. Single transfer
   - Stimulus: WIDTH=8, NUM_IN=4, d_in={8'h44,8'h33,8'h22,8'h11}, select_bits=2, in_valid for 1 cycle, out_ready=1.
   - Required: next cycle out_valid=1, data_out=8'h33, sel_out=2.
3. Streaming
   - Stimulus: select_bits cycles 0,1,2,3 with in_valid=1 and out_ready=1 continuously.
   - Required: outputs 11,22,33,44 on consecutive cycles, one per cycle, in_ready never low.
4. Backpressure
   - Stimulus: out_ready=0 while sending 2 words (sel=1 then 3).
   - Required: in_ready drops after the second word. Raising out_ready yields 22 then 44, with in_ready=1 again after the skid drains.
5. Stall
   - Stimulus: stage_wait=1 for 5 cycles with in_valid=1 and out_ready=1, changing d_in each cycle.
   - Required: in_ready=0 throughout and data_out/out_valid frozen. After release, only words presented post-stall are captured.
6. Error select
   - Stimulus: NUM_IN=3, select_bits=3.
   - Required: out_valid=1, data_out=0, sel_err=1, sel_out=3. The next valid select clears sel_err.
